// File: rtl/muldiv_unit_pkg.sv
// Shared xgriscv defines: M-extension funct3 op codes and muldiv FSM states.
package xgriscv_defines;

    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2,
        MD_ST_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negate: absolute value on the way in, sign restore on the way out.
module muldiv_signfix #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);
    always_comb dout = neg ? (~din + W'(1)) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, one result bit per cycle.
// Define MULDIV_FAST_MUL_EN to complete multiplies in a single cycle.
module muldiv_unit
    import xgriscv_defines::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic         clk,
    input logic         reset,
    input logic         flush,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_r;
    logic [XLEN:0]     opnd;
    logic [2*XLEN-1:0] acc;
    logic              neg_main, neg_rem;
    logic [XLEN-1:0]   result_r;

    logic              accept, sa, sb, div_zero, div_ovf, short_path;
    logic [XLEN:0]     mag_a, mag_b;
    logic [XLEN-1:0]   special_res, short_res;

    assign accept = bus.in_valid && (state == MD_ST_IDLE);
    assign sa     = md_a_signed(bus.op) & bus.a[XLEN-1];
    assign sb     = md_b_signed(bus.op) & bus.b[XLEN-1];

    muldiv_signfix #(.W(XLEN+1)) u_abs_a (.din({sa, bus.a}), .neg(sa), .dout(mag_a));
    muldiv_signfix #(.W(XLEN+1)) u_abs_b (.din({sb, bus.b}), .neg(sb), .dout(mag_b));

    assign div_zero    = md_is_div(bus.op) && (bus.b == '0);
    assign div_ovf     = ((bus.op == MD_OP_DIV) || (bus.op == MD_OP_REM)) &&
                         (bus.a == MOST_NEG) && (bus.b == '1);
    assign special_res = div_zero ? (bus.op[1] ? bus.a : '1)
                                  : (bus.op[1] ? '0 : bus.a);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{XLEN{sa}}, bus.a};
    assign ext_b     = {{XLEN{sb}}, bus.b};
    assign fast_prod = ext_a * ext_b;
`endif

    always_comb begin
        short_path = div_zero | div_ovf;
        short_res  = special_res;
`ifdef MULDIV_FAST_MUL_EN
        if (!md_is_div(bus.op)) begin
            short_path = 1'b1;
            short_res  = (bus.op == MD_OP_MUL) ? fast_prod[XLEN-1:0]
                                               : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum, trial;
    logic              ge;
    logic [XLEN-1:0]   rem_nx;
    logic [2*XLEN-1:0] acc_step;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? opnd : '0);
    assign trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign ge       = (trial >= opnd);
    assign rem_nx   = ge ? (trial[XLEN-1:0] - opnd[XLEN-1:0]) : trial[XLEN-1:0];
    assign acc_step = md_is_div(op_r) ? {rem_nx, acc[XLEN-2:0], ge}
                                      : {mul_sum, acc[XLEN-1:1]};

    logic [2*XLEN-1:0] fix_in, fixed;
    logic              fix_neg;
    logic [XLEN-1:0]   fix_res;

    assign fix_in  = !md_is_div(op_r) ? acc
                   : (op_r[1] ? {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]}
                              : {{XLEN{1'b0}}, acc[XLEN-1:0]});
    assign fix_neg = (md_is_div(op_r) && op_r[1]) ? neg_rem : neg_main;

    muldiv_signfix #(.W(2*XLEN)) u_fix (.din(fix_in), .neg(fix_neg), .dout(fixed));

    assign fix_res = ((op_r == MD_OP_MUL) || md_is_div(op_r)) ? fixed[XLEN-1:0]
                                                             : fixed[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (reset) state <= MD_ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            MD_ST_IDLE: if (bus.in_valid) state_nx = short_path ? MD_ST_DONE : MD_ST_CALC;
            MD_ST_CALC: if (cnt == '0) state_nx = MD_ST_FIX;
            MD_ST_FIX:  state_nx = MD_ST_DONE;
            MD_ST_DONE: if (bus.out_ready) state_nx = MD_ST_IDLE;
            default:    state_nx = MD_ST_IDLE;
        endcase
        if (flush) state_nx = MD_ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_r     <= '0;
            opnd     <= '0;
            acc      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result_r <= '0;
        end else begin
            unique case (state)
                MD_ST_IDLE: if (accept) begin
                    op_r     <= bus.op;
                    neg_main <= sa ^ sb;
                    neg_rem  <= sa;
                    cnt      <= CW'(XLEN-1);
                    opnd     <= md_is_div(bus.op) ? mag_b : mag_a;
                    acc      <= {{XLEN{1'b0}}, md_is_div(bus.op) ? mag_a[XLEN-1:0]
                                                                 : mag_b[XLEN-1:0]};
                    if (short_path) result_r <= short_res;
                end
                MD_ST_CALC: begin
                    acc <= acc_step;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                MD_ST_FIX: result_r <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == MD_ST_IDLE);
    assign bus.out_valid = (state == MD_ST_DONE);
    assign bus.busy      = (state == MD_ST_CALC) || (state == MD_ST_FIX);
    assign bus.result    = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32); honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    import xgriscv_defines::*;

    localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive at a negedge, accept on the next posedge, return at the following negedge
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        start_op(op, a, b);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_res"}, 64'(bus.result), 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("mul_7xm3",   MD_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mulhu_ff",   MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mulh_m1m1",  MD_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        do_op("mulhsu_m1",  MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        do_op("mulh_minsq", MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        do_op("div_m7_2",   MD_OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
        do_op("rem_m7_2",   MD_OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
        do_op("divu_big",   MD_OP_DIVU,   32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, DIV_LAT);
        do_op("div_100_m7", MD_OP_DIV,    32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT);
        do_op("rem_100_m7", MD_OP_REM,    32'd100,      32'hFFFF_FFF9, 32'd2,         DIV_LAT);
        do_op("divu_z",     MD_OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("remu_z",     MD_OP_REMU,   32'd5,        32'd0,        32'd5,         1);
        do_op("div_ovf",    MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",    MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // backpressure: result held, new requests ignored while DONE
        start_op(MD_OP_DIVU, 32'd100, 32'd7);
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_lat", 64'(cyc), 64'(DIV_LAT));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = MD_OP_MUL;
            bus.a        = 32'd3;
            bus.b        = 32'd3;
            @(negedge clk);
            check("bp_result",   64'(bus.result),    64'd14);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready),  64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_valid", 64'(bus.out_valid), 64'd0);
        check("bp_rel_ready", 64'(bus.in_ready),  64'd1);

        // flush mid-divide
        start_op(MD_OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("fl_busy", 64'(bus.busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_in_ready", 64'(bus.in_ready), 64'd1);
        check("fl_busy_off", 64'(bus.busy),     64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        check("fl_no_valid", 64'(seen_valid), 64'd0);
        do_op("fl_next", MD_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, DIV_LAT);

        // reset mid-multiply
        start_op(MD_OP_MULHU, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rs_in_ready", 64'(bus.in_ready),  64'd1);
        check("rs_valid",    64'(bus.out_valid), 64'd0);
        check("rs_result",   64'(bus.result),    64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        check("rs_no_valid", 64'(seen_valid), 64'd0);
        do_op("rs_next", MD_OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply–divide unit, parametrised in `XLEN`, sitting beside the single-cycle ALU in the execute stage. It accepts one operation through a valid/ready handshake and computes it over multiple cycles: one quotient or product bit per cycle. It returns the result through a second valid/ready handshake, so the pipeline stalls on `in_ready`/`out_valid`. Operation encoding equals instruction funct3, so decode passes funct3 straight through.

## Interface
- `XLEN`, default 32: operand/result width; 32 or 64.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `flush`  in  1  synchronous kill of any in-flight op (pipeline redirect).
- `in_valid`  in  1  operands and `op` valid.
- `in_ready`  out  1  high only in IDLE.
- `op`  in  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- `a`, `b`  in  XLEN  rs1, rs2 values.
- `out_valid`  out  1  result available; held until accepted.
- `out_ready`  in  1  consumer takes result.
- `result`  out  XLEN  result; stable while `out_valid`.
- `busy`  out  1  high in CALC or FIX.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `in_ready`=1. Accept on `in_valid & in_ready`. Latch `op`, operand magnitudes and sign flags; load counter = XLEN-1.
  - Signed operands: MULH both, MULHSU `a` only, DIV/REM both.
- Special cases at accept go IDLE→DONE directly, result formed combinationally and registered:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `a`.
  - Signed overflow (`a`=most negative, `b`=−1): DIV → `a`; REM → 0.
- CALC: one iteration per cycle.
  - Multiply: shift-add on a 2·XLEN accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements; at 0 → FIX.
- FIX, one cycle: apply sign correction.
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Select low half (MUL), high half (MULH*), quotient or remainder. → DONE.
- DONE: `out_valid`=1. On `out_ready` → IDLE.
  - `in_ready` stays 0 in DONE: no accept in the same cycle as the handoff.
- `flush` in any state → IDLE next edge, `out_valid` dropped, result discarded; `flush` outranks `out_ready` and `in_valid`.
- `reset` outranks `flush`.
- Arithmetic: internal datapath XLEN+1 bits for magnitudes. Magnitude of the most negative value is handled unsigned, so there is no overflow inside the datapath.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, state IDLE, counter 0.
- Iterative path: accept at edge E. CALC occupies edges E+1..E+XLEN, FIX at edge E+XLEN+1. `out_valid` is high in the cycle after edge E+XLEN+1, i.e. latency XLEN+2 cycles (34 for XLEN=32).
- Special case: `out_valid` in the cycle after the accept edge (latency 1).
- Backpressure: `result` and `out_valid` hold indefinitely while `out_ready`=0.
- Throughput: one op per latency+1 cycles minimum (one IDLE cycle between ops).

## Configuration
- `MULDIV_FAST_MUL_EN` defined: multiplies use a single-cycle XLEN×XLEN (XLEN+1 signed) multiplier. Accept → DONE, latency 1. Divides unchanged.
- Undefined: multiplies use the iterative CALC/FIX path with latency XLEN+2; no hardware multiplier is inferred.

## Structure
- The shared package `xgriscv_defines` gets:
  - the `MD_OP_*` funct3 constants;
  - the state encoding `MD_ST_IDLE/CALC/FIX/DONE` (2 bits).
- Sub-module `muldiv_signfix`: combinational abs-value-in / conditional-negate-out helper. Used at operand latch and in FIX.

## Test plan
- MUL 7 × −3 (0xFFFFFFFD), iterative → `result`=0xFFFFFFEB, `out_valid` exactly 34 cycles after accept.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5%0 → 5, each with latency 1; DIV 0x80000000/−1 → 0x80000000, REM → 0, latency 1.
- Hold `out_ready`=0 for 5 cycles in DONE → `result` stable, `in_ready`=0, `in_valid` ignored; release → IDLE next edge.
- `flush` at cycle 10 of a DIV → IDLE and `in_ready`=1 next cycle, no `out_valid` ever; the next op completes correctly. `reset` mid-CALC gives the same behaviour.
